// File: rtl/centroid_update_engine_pkg.sv
// Shared constants, FSM encoding and reset-centroid helper for the
// centroid update engine.
package centroid_update_engine_pkg;

    localparam int K     = 16;
    localparam int PIX_W = 8;
    localparam int SUM_W = 20;
    localparam int CNT_W = 12;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Centroids start evenly spread over the component range, mid-bucket.
    function automatic logic [PIX_W-1:0] init_centroid(input int unsigned idx);
        int unsigned val;
        val = idx * ((2 ** PIX_W) / K) + ((2 ** PIX_W) / (2 * K));
        init_centroid = val[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/cluster_accumulator_lane.sv
// One cluster's component sum and member count, saturating on count so that
// neither register can ever wrap.
module cluster_accumulator_lane
    import centroid_update_engine_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             hit,
    input  logic             clear,
    input  logic [PIX_W-1:0] value,
    output logic [SUM_W-1:0] sum,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             sat_drop
);

    logic [SUM_W-1:0] sum_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;

    assign full_s   = (count_r == {CNT_W{1'b1}});
    assign sat_drop = hit & full_s;

    // Sum/count registers: cleared per frame, frozen once the count is full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_r   <= {SUM_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            sum_r   <= {SUM_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (hit && !full_s) begin
            sum_r   <= sum_r + SUM_W'(value);
            count_r <= count_r + CNT_W'(1'b1);
        end
    end

    assign sum     = sum_r;
    assign count   = count_r;
    assign nonzero = |count_r;

endmodule

// File: rtl/centroid_update_engine.sv
// Accumulates per-cluster sums/counts over a frame, hands them to the divider
// bank and captures the quotients as the new centroids.
module centroid_update_engine
    import centroid_update_engine_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [PIX_W-1:0]     pix_value,
    input  logic [IDX_W-1:0]     pix_cluster,
    input  logic                 frame_end,
    output logic [K-1:0]         div_en,
    output logic [K*SUM_W-1:0]   div_dividend,
    output logic [K*CNT_W-1:0]   div_divisor,
    input  logic                 div_all_ready,
    input  logic [K*SUM_W-1:0]   div_quotient,
    output logic [K*PIX_W-1:0]   centroid,
    output logic                 centroid_valid,
    output logic                 cnt_overflow
);

    state_t               state_r, next_state_s;
    logic                 wait_first_r;
    logic [K-1:0]         div_en_r;
    logic [K*PIX_W-1:0]   centroid_r;
    logic                 centroid_valid_r;
    logic                 cnt_overflow_r;

    logic                 accept_s;
    logic                 last_s;
    logic                 clear_s;
    logic [K-1:0]         hit_s;
    logic [K-1:0]         nonzero_s;
    logic [K-1:0]         nonzero_after_s;
    logic [K-1:0]         sat_drop_s;
    logic                 quotient_unused_s;

    assign accept_s = pix_valid && (state_r == ACCUM);
    assign last_s   = accept_s && frame_end;
    assign clear_s  = (state_r == CAPTURE);

    // A hit on a full lane is dropped, but that lane is already nonzero.
    assign nonzero_after_s = nonzero_s | hit_s;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_lane
            assign hit_s[gi] = accept_s && (pix_cluster == IDX_W'(gi));

            cluster_accumulator_lane u_lane (
                .clk      (clk),
                .reset    (reset),
                .hit      (hit_s[gi]),
                .clear    (clear_s),
                .value    (pix_value),
                .sum      (div_dividend[gi*SUM_W +: SUM_W]),
                .count    (div_divisor[gi*CNT_W +: CNT_W]),
                .nonzero  (nonzero_s[gi]),
                .sat_drop (sat_drop_s[gi])
            );
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ACCUM;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; the first WAIT cycle ignores the bank's stale ready.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ACCUM: begin
                if (last_s) begin
                    if (|nonzero_after_s) begin
                        next_state_s = WAIT;
                    end else begin
                        next_state_s = CAPTURE;
                    end
                end else begin
                    next_state_s = ACCUM;
                end
            end
            WAIT: begin
                if (!wait_first_r && div_all_ready) begin
                    next_state_s = CAPTURE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            CAPTURE: next_state_s = ACCUM;
            default: next_state_s = ACCUM;
        endcase
    end

    // Divider enables, centroid capture, valid pulse and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_first_r     <= 1'b0;
            div_en_r         <= {K{1'b0}};
            centroid_valid_r <= 1'b0;
            cnt_overflow_r   <= 1'b0;
            for (int i = 0; i < K; i++) begin
                centroid_r[i*PIX_W +: PIX_W] <= init_centroid(i);
            end
        end else begin
            wait_first_r     <= (state_r == ACCUM) && (next_state_s == WAIT);
            centroid_valid_r <= (state_r == CAPTURE);
            if ((state_r == ACCUM) && (next_state_s == WAIT)) begin
                div_en_r <= nonzero_after_s;
            end else if (next_state_s != WAIT) begin
                div_en_r <= {K{1'b0}};
            end
            if (state_r == CAPTURE) begin
                cnt_overflow_r <= 1'b0;
            end else if (|sat_drop_s) begin
                cnt_overflow_r <= 1'b1;
            end
            for (int i = 0; i < K; i++) begin
                if ((state_r == CAPTURE) && nonzero_s[i]) begin
                    centroid_r[i*PIX_W +: PIX_W] <= div_quotient[i*SUM_W +: PIX_W];
                end
            end
        end
    end

    // Quotient bits above the component width are zero by construction.
    always_comb begin
        quotient_unused_s = 1'b0;
        for (int i = 0; i < K; i++) begin
            quotient_unused_s = quotient_unused_s ^ (^div_quotient[i*SUM_W+PIX_W +: SUM_W-PIX_W]);
        end
    end

    assign pix_ready      = (state_r == ACCUM);
    assign div_en         = div_en_r;
    assign centroid       = centroid_r;
    assign centroid_valid = centroid_valid_r;
    assign cnt_overflow   = cnt_overflow_r;

endmodule

// File: tb/tb_centroid_update_engine.sv
// Randomized self-checking bench: a plain arithmetic frame model (sums, counts,
// saturation, mean) plus a behavioural divider bank with variable delay.
module tb_centroid_update_engine;
    import centroid_update_engine_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 pix_valid = 1'b0;
    logic                 pix_ready;
    logic [PIX_W-1:0]     pix_value = 8'd0;
    logic [IDX_W-1:0]     pix_cluster = 4'd0;
    logic                 frame_end = 1'b0;
    logic [K-1:0]         div_en;
    logic [K*SUM_W-1:0]   div_dividend;
    logic [K*CNT_W-1:0]   div_divisor;
    logic                 div_all_ready = 1'b0;
    logic [K*SUM_W-1:0]   div_quotient = '0;
    logic [K*PIX_W-1:0]   centroid;
    logic                 centroid_valid;
    logic                 cnt_overflow;

    centroid_update_engine dut (
        .clk            (clk),
        .reset          (reset),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_value      (pix_value),
        .pix_cluster    (pix_cluster),
        .frame_end      (frame_end),
        .div_en         (div_en),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_all_ready  (div_all_ready),
        .div_quotient   (div_quotient),
        .centroid       (centroid),
        .centroid_valid (centroid_valid),
        .cnt_overflow   (cnt_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned msum [K];
    int unsigned mcnt [K];
    int unsigned mcen [K];
    bit          movf;

    task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model_clear_frame();
        for (int i = 0; i < K; i++) begin
            msum[i] = 0;
            mcnt[i] = 0;
        end
        movf = 1'b0;
    endfunction

    function automatic void model_init();
        model_clear_frame();
        for (int i = 0; i < K; i++) mcen[i] = i * 16 + 8;
    endfunction

    function automatic void model_accept(input int unsigned v, input int unsigned c);
        if (mcnt[c] == 4095) movf = 1'b1;
        else begin
            msum[c] += v;
            mcnt[c] += 1;
        end
    endfunction

    function automatic logic [K*SUM_W-1:0] model_sums();
        logic [K*SUM_W-1:0] r;
        for (int i = 0; i < K; i++) r[i*SUM_W +: SUM_W] = msum[i][SUM_W-1:0];
        return r;
    endfunction

    task automatic check_centroids(input string tag);
        for (int i = 0; i < K; i++)
            check_eq($sformatf("%s_c%0d", tag, i), centroid[i*PIX_W +: PIX_W], mcen[i]);
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send_pixel(input int unsigned v, input int unsigned c, input bit fe);
        int guard = 0;
        pix_value   = v[PIX_W-1:0];
        pix_cluster = c[IDX_W-1:0];
        frame_end   = fe;
        pix_valid   = 1'b1;
        while (!pix_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check_eq("accept_timeout", guard, 0);
        @(negedge clk);
        pix_valid = 1'b0;
        frame_end = 1'b0;
        model_accept(v, c);
    endtask

    // Called at the negedge just after frame_end was accepted (engine in WAIT).
    task automatic do_divide(input int d);
        int lat;
        logic [31:0] rnd;
        logic [SUM_W-1:0] q;
        check_eq("wait_pix_ready", pix_ready, 0);
        check_eq("wait_ovf", cnt_overflow, movf);
        for (int i = 0; i < K; i++) begin
            check_eq($sformatf("div_en%0d", i), div_en[i], mcnt[i] != 0);
            check_eq($sformatf("dividend%0d", i), div_dividend[i*SUM_W +: SUM_W], msum[i]);
            check_eq($sformatf("divisor%0d", i), div_divisor[i*CNT_W +: CNT_W], mcnt[i]);
            rnd = $urandom;
            if (mcnt[i] != 0) q = SUM_W'(msum[i] / mcnt[i]) | {rnd[11:0], 8'h00};
            else q = rnd[SUM_W-1:0];
            div_quotient[i*SUM_W +: SUM_W] = q;
        end
        if (d == 0) div_all_ready = 1'b1;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (centroid_valid) break;
            if (lat == 2) begin
                check_eq("wait_hold_sums", div_dividend == model_sums(), 1);
                check_eq("wait_hold_ready", pix_ready, 0);
            end
            if (lat == d) div_all_ready = 1'b1;
        end
        check_eq("valid_latency", lat, ((d < 1) ? 1 : d) + 2);
        for (int i = 0; i < K; i++)
            if (mcnt[i] != 0) mcen[i] = msum[i] / mcnt[i];
        check_centroids("capture");
        check_eq("post_div_en", div_en, 0);
        check_eq("post_ovf", cnt_overflow, 0);
        div_all_ready = 1'b0;
        model_clear_frame();
        @(negedge clk);
        check_eq("valid_pulse", centroid_valid, 0);
        if (pix_valid) begin
            model_accept(pix_value, pix_cluster);
            pix_valid = 1'b0;
        end
    endtask

    task automatic random_frame(input int npix);
        logic [15:0] mask;
        int unsigned c;
        mask = 16'($urandom_range(1, 65535));
        for (int p = 0; p < npix; p++) begin
            do c = $urandom_range(0, K - 1); while (!mask[c]);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_pixel($urandom_range(0, 255), c, p == npix - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vsum;
        model_init();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_centroids("reset");
        check_eq("reset_ready", pix_ready, 1);
        check_eq("reset_div_en", div_en, 0);
        check_eq("reset_ovf", cnt_overflow, 0);
        vsum = 0;
        repeat (5) begin
            @(negedge clk);
            vsum += centroid_valid;
        end
        check_eq("idle_no_valid", vsum, 0);

        // Directed frame: cluster 3 mean 20, cluster 7 single pixel 200.
        send_pixel(10, 3, 1'b0);
        send_pixel(20, 3, 1'b0);
        send_pixel(30, 3, 1'b0);
        send_pixel(200, 7, 1'b1);
        check_eq("t2_div_en", div_en, 16'h0088);
        check_eq("t2_dividend3", div_dividend[3*SUM_W +: SUM_W], 60);
        check_eq("t2_divisor3", div_divisor[3*CNT_W +: CNT_W], 3);
        check_eq("t2_dividend7", div_dividend[7*SUM_W +: SUM_W], 200);
        check_eq("t2_divisor7", div_divisor[7*CNT_W +: CNT_W], 1);
        do_divide(5);
        check_eq("t2_centroid3", centroid[3*PIX_W +: PIX_W], 20);
        check_eq("t2_centroid7", centroid[7*PIX_W +: PIX_W], 200);

        // Ready held high from the first WAIT cycle.
        random_frame(8);
        do_divide(0);

        // Pixel presented during WAIT/CAPTURE must wait for ACCUM.
        random_frame(6);
        pix_value   = 8'd77;
        pix_cluster = 4'd5;
        pix_valid   = 1'b1;
        do_divide(4);
        random_frame(5);
        do_divide(1);

        // Count saturation on cluster 0.
        for (int p = 0; p < 4096; p++) send_pixel(255, 0, p == 4095);
        check_eq("sat_divisor0", div_divisor[0 +: CNT_W], 4095);
        check_eq("sat_dividend0", div_dividend[0 +: SUM_W], 1044225);
        check_eq("sat_ovf", cnt_overflow, 1);
        do_divide(2);
        check_eq("sat_centroid0", centroid[0 +: PIX_W], 255);

        // Asynchronous reset while waiting on the divider bank.
        random_frame(12);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_init();
        check_eq("rst_wait_div_en", div_en, 0);
        check_eq("rst_wait_ready", pix_ready, 1);
        check_centroids("rst_wait");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        random_frame(20);
        do_divide(3);

        for (int f = 0; f < 6; f++) begin
            random_frame($urandom_range(1, 60));
            do_divide($urandom_range(0, 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
